// File: rtl/mips_bus_master.sv
// Purpose: bridges single CPU load/store requests onto a word-wide waitrequest-style memory bus.
// Latency: resp_valid 3 cycles after a store, 4 after a load, 2 after a rejected request, plus stall cycles.
// Backpressure: one request in flight (req_ready only in IDLE); bus stalls via waitrequest, bounded by TIMEOUT.
module mips_bus_master #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  input  logic [31:0] readdata,
  input  logic        waitrequest
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BUS   = 2'd1;
  localparam logic [1:0] RDATA = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic [1:0]    state_q, state_d;
  logic          is_wr_q, is_wr_d;
  logic [1:0]    size_q, size_d;
  logic          sgn_q, sgn_d;
  logic [1:0]    lo_q, lo_d;
  logic          err_q, err_d;
  logic [31:0]   res_q, res_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rd_q, rd_d;
  logic          wr_q, wr_d;
  logic [31:0]   address_q, address_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   wd_q, wd_d;
  logic          resp_valid_q, resp_valid_d;
  logic [31:0]   resp_rdata_q, resp_rdata_d;
  logic          resp_error_q, resp_error_d;

  logic          misalign;
  logic [3:0]    be_calc;
  logic [31:0]   wd_calc;
  logic [31:0]   rd_shift;
  logic [31:0]   rd_ext;

  // Request decode: alignment check, lane enables and lane-replicated store data.
  always_comb begin
    misalign = (req_size == 2'b11)
             | ((req_size == SZ_HALF) & req_addr[0])
             | ((req_size == SZ_WORD) & (req_addr[1:0] != 2'b00));
    case (req_size)
      SZ_BYTE: begin
        be_calc = 4'b0001 << req_addr[1:0];
        wd_calc = {4{req_wdata[7:0]}};
      end
      SZ_HALF: begin
        be_calc = 4'b0011 << req_addr[1:0];
        wd_calc = {2{req_wdata[15:0]}};
      end
      default: begin
        be_calc = 4'b1111;
        wd_calc = req_wdata;
      end
    endcase
  end

  // Load result: shift the addressed lanes down to bit 0, then zero- or sign-extend.
  always_comb begin
    rd_shift = readdata >> {lo_q, 3'b000};
    case (size_q)
      SZ_BYTE: rd_ext = sgn_q ? {{24{rd_shift[7]}}, rd_shift[7:0]} : {24'h0, rd_shift[7:0]};
      SZ_HALF: rd_ext = sgn_q ? {{16{rd_shift[15]}}, rd_shift[15:0]} : {16'h0, rd_shift[15:0]};
      default: rd_ext = rd_shift;
    endcase
  end

  // Transaction FSM and next-state values for every registered output.
  always_comb begin
    state_d      = state_q;
    is_wr_d      = is_wr_q;
    size_d       = size_q;
    sgn_d        = sgn_q;
    lo_d         = lo_q;
    err_d        = err_q;
    res_d        = res_q;
    cnt_d        = cnt_q;
    rd_d         = rd_q;
    wr_d         = wr_q;
    address_d    = address_q;
    be_d         = be_q;
    wd_d         = wd_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_error_d = resp_error_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          is_wr_d = req_write;
          size_d  = req_size;
          sgn_d   = req_signed;
          lo_d    = req_addr[1:0];
          res_d   = 32'h0;
          err_d   = misalign;
          if (misalign) begin
            // Rejected requests never touch the bus.
            state_d = RESP;
          end else begin
            state_d   = BUS;
            address_d = {req_addr[31:2], 2'b00};
            be_d      = be_calc;
            wd_d      = wd_calc;
            cnt_d     = '0;
            rd_d      = ~req_write;
            wr_d      = req_write;
          end
        end
      end
      BUS: begin
        if (!waitrequest) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = is_wr_q ? RESP : RDATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
          // Give up once the responder has stalled for TIMEOUT cycles.
          if (cnt_d == CW'(TIMEOUT)) begin
            rd_d    = 1'b0;
            wr_d    = 1'b0;
            err_d   = 1'b1;
            res_d   = 32'h0;
            state_d = RESP;
          end
        end
      end
      RDATA: begin
        res_d   = rd_ext;
        state_d = RESP;
      end
      default: begin
        // Results are published together with the pulse so they stay stable until the next one.
        resp_valid_d = 1'b1;
        resp_rdata_d = res_q;
        resp_error_d = err_q;
        state_d      = IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      is_wr_q      <= 1'b0;
      size_q       <= 2'b00;
      sgn_q        <= 1'b0;
      lo_q         <= 2'b00;
      err_q        <= 1'b0;
      res_q        <= 32'h0;
      cnt_q        <= '0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      address_q    <= 32'h0;
      be_q         <= 4'h0;
      wd_q         <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      is_wr_q      <= is_wr_d;
      size_q       <= size_d;
      sgn_q        <= sgn_d;
      lo_q         <= lo_d;
      err_q        <= err_d;
      res_q        <= res_d;
      cnt_q        <= cnt_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      address_q    <= address_d;
      be_q         <= be_d;
      wd_q         <= wd_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_error_q <= resp_error_d;
    end
  end

  assign req_ready  = (state_q == IDLE) & reset;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_error = resp_error_q;
  assign address    = address_q;
  assign read       = rd_q;
  assign write      = wr_q;
  assign byteenable = be_q;
  assign writedata  = wd_q;

endmodule
